// File: rtl/if_fetch_if.sv
// Fetch-stage handshake bundle: instruction-memory request/response plus decode-side hand-off.
// Pure wiring, no latency of its own.
// Backpressure: imem_req_ready stalls requests, id_ready stalls the decode queue.
interface if_fetch_if #(
  parameter int CPU_WIDTH = 32
);
  logic                 imem_req_valid;
  logic [CPU_WIDTH-1:0] imem_req_addr;
  logic                 imem_req_ready;
  logic                 imem_rsp_valid;
  logic [CPU_WIDTH-1:0] imem_rsp_data;
  logic                 id_valid;
  logic                 id_ready;
  logic [CPU_WIDTH-1:0] id_pc;
  logic [CPU_WIDTH-1:0] id_instr;

  // Fetch stage side: issues requests, takes responses, presents entries to decode.
  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data,
    output id_valid,
    input  id_ready,
    output id_pc,
    output id_instr
  );

  // Environment side: instruction memory plus decode.
  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data,
    input  id_valid,
    output id_ready,
    input  id_pc,
    input  id_instr
  );
endinterface

// File: rtl/if_fetch.sv
// Instruction fetch: in-order imem requests from curr_pc, {pc,instr} buffered for decode.
// Latency: request accept to id_valid is memory latency + 1 cycle (no response bypass).
// Backpressure: credit (outstanding + buffered < DEPTH) gates requests; flush drops all.
// Optional misaligned-PC check enabled by defining IF_MISALIGN_CHK_EN.
module if_fetch #(
  parameter int CPU_WIDTH = 32,
  parameter int DEPTH     = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena,
  input  logic [CPU_WIDTH-1:0] curr_pc,
  input  logic                 flush,
  output logic                 pc_advance,
  output logic                 misalign_err,
  if_fetch_if.master           bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Request/response bookkeeping
  logic [CW-1:0]        out_cnt_q, out_cnt_d;
  logic [CW-1:0]        drop_q, drop_d;
  logic [CW-1:0]        fifo_cnt_q, fifo_cnt_d;
  logic [CW:0]          used;
  logic                 credit;
  logic                 req_vld;
  logic                 accept;
  logic                 rsp_keep;
  logic                 push;
  logic                 pop;

  // PCs of live (non-dropped) requests, oldest first
  logic [CPU_WIDTH-1:0] pend_pc_q [DEPTH];
  logic [AW-1:0]        pend_wr_q;
  logic [AW-1:0]        pend_rd_q;

  // Decode-side FIFO storage
  logic [CPU_WIDTH-1:0] fifo_pc_q    [DEPTH];
  logic [CPU_WIDTH-1:0] fifo_instr_q [DEPTH];
  logic [AW-1:0]        fifo_wr_q;
  logic [AW-1:0]        fifo_rd_q;

  // Buffered entries plus in-flight requests may never exceed the FIFO depth, so
  // every returning response is guaranteed a free slot.
  assign used   = {1'b0, out_cnt_q} + {1'b0, fifo_cnt_q};
  assign credit = used < (CW+1)'(DEPTH);

`ifdef IF_MISALIGN_CHK_EN
  logic misalign;
  logic err_q;

  assign misalign           = curr_pc[1:0] != 2'b00;
  assign req_vld            = ena & credit & ~flush & ~misalign;
  assign bus.imem_req_addr  = curr_pc;
  assign misalign_err       = err_q;

  // Sticky misalign flag; only a redirect (or reset) clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (flush) begin
      err_q <= 1'b0;
    end else if (ena && misalign) begin
      err_q <= 1'b1;
    end
  end
`else
  assign req_vld            = ena & credit & ~flush;
  // Low PC bits are ignored: fetch is always word aligned.
  assign bus.imem_req_addr  = curr_pc & ~CPU_WIDTH'(3);
  assign misalign_err       = 1'b0;
`endif

  assign bus.imem_req_valid = req_vld;
  assign accept             = req_vld & bus.imem_req_ready;
  assign pc_advance         = accept;

  // A response is kept only when no drop debt is pending and no redirect is in progress.
  assign rsp_keep = bus.imem_rsp_valid & ~flush & (drop_q == '0);
  assign push     = rsp_keep;
  assign pop      = (fifo_cnt_q != '0) & bus.id_ready & ~flush;

  assign bus.id_valid = fifo_cnt_q != '0;
  assign bus.id_pc    = fifo_pc_q[fifo_rd_q];
  assign bus.id_instr = fifo_instr_q[fifo_rd_q];

  // Next-state for counters; a redirect turns every still-outstanding request into drop debt.
  always_comb begin
    out_cnt_d  = out_cnt_q + CW'(accept) - CW'(bus.imem_rsp_valid);
    drop_d     = drop_q;
    fifo_cnt_d = fifo_cnt_q;
    if (flush) begin
      // The response arriving in the flush cycle is discarded and retires its own slot.
      drop_d     = out_cnt_q - CW'(bus.imem_rsp_valid);
      fifo_cnt_d = '0;
    end else begin
      if (bus.imem_rsp_valid && (drop_q != '0)) begin
        drop_d = drop_q - CW'(1);
      end
      fifo_cnt_d = fifo_cnt_q + CW'(push) - CW'(pop);
    end
  end

  // Counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_cnt_q  <= '0;
      drop_q     <= '0;
      fifo_cnt_q <= '0;
    end else begin
      out_cnt_q  <= out_cnt_d;
      drop_q     <= drop_d;
      fifo_cnt_q <= fifo_cnt_d;
    end
  end

  // Pending-PC queue: push on accept, pop when a kept response consumes its PC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_wr_q <= '0;
      pend_rd_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pend_pc_q[i] <= '0;
      end
    end else if (flush) begin
      pend_wr_q <= '0;
      pend_rd_q <= '0;
    end else begin
      if (accept) begin
        pend_pc_q[pend_wr_q] <= curr_pc;
        pend_wr_q            <= pend_wr_q + AW'(1);
      end
      if (rsp_keep) begin
        pend_rd_q <= pend_rd_q + AW'(1);
      end
    end
  end

  // Decode FIFO: write {pc, instr} on kept response, advance head on decode pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_wr_q <= '0;
      fifo_rd_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_pc_q[i]    <= '0;
        fifo_instr_q[i] <= '0;
      end
    end else if (flush) begin
      fifo_wr_q <= '0;
      fifo_rd_q <= '0;
    end else begin
      if (push) begin
        fifo_pc_q[fifo_wr_q]    <= pend_pc_q[pend_rd_q];
        fifo_instr_q[fifo_wr_q] <= bus.imem_rsp_data;
        fifo_wr_q               <= fifo_wr_q + AW'(1);
      end
      if (pop) begin
        fifo_rd_q <= fifo_rd_q + AW'(1);
      end
    end
  end

  // Memory must never answer a request that was not issued.
  a_rsp_has_outstanding: assert property (
    @(posedge clk) disable iff (!rst_n) bus.imem_rsp_valid |-> (out_cnt_q != '0)
  );

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: queue-level fetch model, in-order memory model,
// per-cycle output comparison and hand-computed literal expectations per scenario.
module tb_if_fetch;
  localparam int W = 32;
  localparam int D = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         ena;
  logic         flush;
  logic [W-1:0] curr_pc;
  logic         pc_advance;
  logic         misalign_err;

  if_fetch_if #(.CPU_WIDTH(W)) bus ();

  if_fetch #(.CPU_WIDTH(W), .DEPTH(D)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ena          (ena),
    .curr_pc      (curr_pc),
    .flush        (flush),
    .pc_advance   (pc_advance),
    .misalign_err (misalign_err),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // stimulus knobs
  logic         s_ena, s_flush, s_rdy, s_id_rdy;
  logic [W-1:0] flush_tgt;
  logic [W-1:0] pc_reg;
  int           mem_lat;
  int           cyc;

  // memory model: accepted addresses with the cycle their response is due
  logic [W-1:0] mem_addr_q[$];
  int           mem_due_q[$];

  // fetch model
  int           m_out, m_drop;
  logic [W-1:0] m_pend[$];
  logic [W-1:0] m_fpc[$];
  logic [W-1:0] m_finstr[$];
  logic         m_err;

  // entries actually handed to decode
  logic [W-1:0] log_pc[$];
  logic [W-1:0] log_instr[$];

  function automatic logic [W-1:0] instr_of(input logic [W-1:0] a);
    return 32'hC0DE_0000 | {16'h0000, a[15:0]};
  endfunction

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // One clock cycle: drive inputs, compare outputs with the model, advance model.
  task automatic step();
    logic         rv, e_rv, e_adv, e_idv, misal;
    logic [W-1:0] e_addr, rdat;
    ena                = s_ena;
    flush              = s_flush;
    curr_pc            = pc_reg;
    bus.imem_req_ready = s_rdy;
    bus.id_ready       = s_id_rdy;
    rv   = (mem_addr_q.size() > 0) && (mem_due_q[0] <= cyc);
    rdat = rv ? instr_of(mem_addr_q[0]) : '0;
    bus.imem_rsp_valid = rv;
    bus.imem_rsp_data  = rdat;
    #1;
`ifdef IF_MISALIGN_CHK_EN
    misal  = pc_reg[1:0] != 2'b00;
    e_addr = pc_reg;
`else
    misal  = 1'b0;
    e_addr = {pc_reg[W-1:2], 2'b00};
`endif
    e_rv  = s_ena && ((m_out + int'(m_fpc.size())) < D) && !s_flush && !misal;
    e_adv = e_rv && s_rdy;
    e_idv = m_fpc.size() > 0;
    chk("req_valid", bus.imem_req_valid, e_rv);
    chk("pc_advance", pc_advance, e_adv);
    if (e_rv) chk("req_addr", bus.imem_req_addr, e_addr);
    chk("id_valid", bus.id_valid, e_idv);
    if (e_idv) begin
      chk("id_pc", bus.id_pc, m_fpc[0]);
      chk("id_instr", bus.id_instr, m_finstr[0]);
    end
    chk("misalign_err", misalign_err, m_err);
    if (e_idv && s_id_rdy && !s_flush) begin
      log_pc.push_back(bus.id_pc);
      log_instr.push_back(bus.id_instr);
    end
    @(posedge clk);
    cyc++;
    if (s_flush) begin
      m_fpc.delete();
      m_finstr.delete();
      m_pend.delete();
      if (rv) m_out--;
      m_drop = m_out;
      m_err  = 1'b0;
      pc_reg = flush_tgt;
    end else begin
      if (e_idv && s_id_rdy) begin
        void'(m_fpc.pop_front());
        void'(m_finstr.pop_front());
      end
      if (rv) begin
        m_out--;
        if (m_drop > 0) m_drop--;
        else begin
          m_fpc.push_back(m_pend.pop_front());
          m_finstr.push_back(rdat);
        end
      end
      if (e_adv) begin
        m_out++;
        m_pend.push_back(pc_reg);
        pc_reg = pc_reg + 4;
      end
      if (s_ena && misal) m_err = 1'b1;
    end
    if (rv) begin
      void'(mem_addr_q.pop_front());
      void'(mem_due_q.pop_front());
    end
    if (e_adv) begin
      mem_addr_q.push_back(e_addr);
      mem_due_q.push_back(cyc + mem_lat - 1);
    end
    @(negedge clk);
  endtask

  task automatic drain();
    s_ena = 1'b0; s_flush = 1'b0; s_id_rdy = 1'b1;
    for (int i = 0; i < 40 && (m_out > 0 || m_fpc.size() > 0); i++) step();
    chk("drain_timeout", m_out + int'(m_fpc.size()), 0);
  endtask

  task automatic redirect(input logic [W-1:0] tgt);
    s_flush = 1'b1; flush_tgt = tgt;
    step();
    s_flush = 1'b0;
  endtask

  task automatic pad_log();
    while (log_pc.size() < 4) begin
      log_pc.push_back('x);
      log_instr.push_back('x);
    end
  endtask

  task automatic clear_log();
    log_pc.delete();
    log_instr.delete();
  endtask

  initial begin
    logic [W-1:0] p0;
    ena = 0; flush = 0; curr_pc = '0;
    bus.imem_req_ready = 0; bus.imem_rsp_valid = 0; bus.imem_rsp_data = '0; bus.id_ready = 0;
    s_ena = 0; s_flush = 0; s_rdy = 0; s_id_rdy = 0; flush_tgt = '0; pc_reg = '0;
    mem_lat = 1; cyc = 0; m_out = 0; m_drop = 0; m_err = 0;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_req_valid", bus.imem_req_valid, 0);
    chk("rst_pc_advance", pc_advance, 0);
    chk("rst_id_valid", bus.id_valid, 0);
    chk("rst_id_pc", bus.id_pc, 0);
    chk("rst_id_instr", bus.id_instr, 0);
    chk("rst_misalign", misalign_err, 0);
    rst_n = 1'b1;

    // 1: in-order stream 0,4,8 with 1-cycle memory
    s_ena = 1; s_rdy = 1; s_id_rdy = 1; mem_lat = 1;
    for (int i = 0; i < 20 && pc_reg != 32'd12; i++) step();
    drain();
    pad_log();
    chk("t1_pc0", log_pc[0], 32'h0);
    chk("t1_in0", log_instr[0], 32'hC0DE_0000);
    chk("t1_pc1", log_pc[1], 32'h4);
    chk("t1_in1", log_instr[1], 32'hC0DE_0004);
    chk("t1_pc2", log_pc[2], 32'h8);
    chk("t1_in2", log_instr[2], 32'hC0DE_0008);
    clear_log();

    // 2: decode stalled, FIFO fills, requests stop, PC holds
    redirect(32'h8);
    s_ena = 1; s_rdy = 1; s_id_rdy = 0; mem_lat = 1;
    repeat (6) step();
    chk("t2_req_valid", bus.imem_req_valid, 0);
    chk("t2_pc_advance", pc_advance, 0);
    chk("t2_id_valid", bus.id_valid, 1);
    chk("t2_id_pc", bus.id_pc, 32'h8);
    chk("t2_id_instr", bus.id_instr, 32'hC0DE_0008);
    chk("t2_pc_hold", curr_pc, 32'h10);
    drain();
    pad_log();
    chk("t2_pc1", log_pc[1], 32'hC);
    clear_log();

    // 3: two outstanding with slow memory, redirect drops both
    s_ena = 1; s_rdy = 1; s_id_rdy = 1; mem_lat = 4;
    repeat (2) step();
    redirect(32'h100);
    s_ena = 1;
    repeat (14) step();
    drain();
    pad_log();
    chk("t3_pc0", log_pc[0], 32'h100);
    chk("t3_in0", log_instr[0], 32'hC0DE_0100);
    chk("t3_pc1", log_pc[1], 32'h104);
    clear_log();

    // 4: redirect in the same cycle as a response and req_ready
    s_ena = 1; s_rdy = 1; s_id_rdy = 1; mem_lat = 2;
    repeat (2) step();
    redirect(32'h200);
    chk("t4_mem_outstanding", mem_addr_q.size(), 1);
    chk("t4_drop_debt", m_drop, 1);
    s_ena = 1;
    repeat (8) step();
    drain();
    pad_log();
    chk("t4_pc0", log_pc[0], 32'h200);
    chk("t4_in0", log_instr[0], 32'hC0DE_0200);
    clear_log();

    // 5: memory not ready for 5 cycles, then a single accept
    redirect(32'h300);
    s_ena = 1; s_rdy = 0; s_id_rdy = 1; mem_lat = 1;
    p0 = pc_reg;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t5_pc_advance", pc_advance, 0);
      chk("t5_addr", bus.imem_req_addr, 32'h300);
    end
    s_rdy = 1;
    step();
    chk("t5_pc_stepped", pc_reg, p0 + 32'h4);
    drain();
    pad_log();
    chk("t5_pc0", log_pc[0], 32'h300);
    chk("t5_count", log_pc[1], 'x);
    clear_log();

    // 6: misaligned PC
    redirect(32'h102);
    s_ena = 1; s_rdy = 1; s_id_rdy = 1; mem_lat = 1;
`ifdef IF_MISALIGN_CHK_EN
    repeat (2) step();
    chk("t6_err_set", misalign_err, 1);
    chk("t6_no_req", bus.imem_req_valid, 0);
    redirect(32'h104);
    chk("t6_err_clr", misalign_err, 0);
    s_ena = 1;
    repeat (3) step();
    drain();
    pad_log();
    chk("t6_pc0", log_pc[0], 32'h104);
`else
    step();
    s_ena = 0;
    drain();
    pad_log();
    chk("t6_pc0", log_pc[0], 32'h102);
    chk("t6_in0", log_instr[0], 32'hC0DE_0100);
    chk("t6_no_err", misalign_err, 0);
`endif
    clear_log();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end
endmodule
